link_slave_rx: RTL

//  Receive side of the 4-phase req/ack byte link. Sits directly downstream of the link master.

---
 rtl/link_slave_rx_pkg.sv | 13 +
 rtl/link_rx_fifo.sv | 52 +++++
 rtl/link_slave_rx.sv | 105 ++++++++++
 3 files changed

// File: rtl/link_slave_rx_pkg.sv
// Shared link definitions: data width, default FIFO depth and the slave handshake phase encodings.
package link_slave_rx_pkg;

  localparam int LINK_DW    = 8;
  localparam int LINK_DEPTH = 4;

  typedef enum logic [1:0] {
    W_REQ    = 2'd0,
    ACK_HI   = 2'd1,
    W_REQ_LO = 2'd2
  } link_state_e;

endpackage

// File: rtl/link_rx_fifo.sv
// Byte FIFO with wrap-bit pointers; rd_data is a combinational read of the head (0 when empty).
// Writes while full and reads while empty are ignored.
module link_rx_fifo
  import link_slave_rx_pkg::*;
#(
  parameter int DEPTH = LINK_DEPTH,
  parameter int DW    = LINK_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/link_slave_rx.sv
// Receive side of the 4-phase req/ack byte link: captures bytes into a FIFO drained over valid/ready.
// Optional running XOR checksum when LINK_RX_CHECKSUM_EN is defined; otherwise checksum reads 0.
module link_slave_rx
  import link_slave_rx_pkg::*;
#(
  parameter int DEPTH    = LINK_DEPTH,
  parameter int ACK_HOLD = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [LINK_DW-1:0] data,
  output logic               ack,
  output logic               out_valid,
  output logic [LINK_DW-1:0] out_data,
  input  logic               out_ready,
  output logic [7:0]         rx_count,
  output logic [LINK_DW-1:0] checksum
);

  localparam int HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACK_HOLD - 1);

  link_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ack_q, ack_d;
  logic [7:0]        rx_count_q, rx_count_d;
  logic              capture;
  logic              fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    capture = 1'b0;
    case (state_q)
      W_REQ: begin
        if (req && !fifo_full) begin
          capture = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        // req is only looked at on the last hold cycle, so ack can fall after exactly ACK_HOLD cycles.
        if (hold_q != '0)  hold_d  = hold_q - HOLD_W'(1);
        else if (req)      state_d = W_REQ_LO;
        else               state_d = W_REQ;
      end
      W_REQ_LO: begin
        if (!req) state_d = W_REQ;
      end
      default: state_d = W_REQ;
    endcase
  end

  assign ack_d      = (state_d != W_REQ);
  assign rx_count_d = capture ? rx_count_q + 8'd1 : rx_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_REQ;
      hold_q     <= '0;
      ack_q      <= 1'b0;
      rx_count_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign ack      = ack_q;
  assign rx_count = rx_count_q;

`ifdef LINK_RX_CHECKSUM_EN
  logic [LINK_DW-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)          csum_q <= '0;
    else if (capture) csum_q <= csum_q ^ data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  link_rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (LINK_DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

endmodule
